fb_pixel_writer: RTL and testbench

Consumer end of the shape-drawing pixel stream: accepts `(x, y, drawing)` from a drawing engine, clips to framebuffer bounds, converts to a linear address and queues writes to framebuffer memory. Applies back-pressure through `oe` so the drawing engine never overruns the queue. Sits between any shape drawer and the framebuffer write port.

---
 rtl/fb_pkg.sv | 16 +
 rtl/fb_pixel_writer_if.sv | 34 +++
 rtl/fb_pixel_writer_fifo_fwft.sv | 70 +++++++
 rtl/fb_pixel_writer.sv | 107 ++++++++++
 tb/tb_fb_pixel_writer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Framebuffer geometry and pixel-queue entry shared by the pixel writer and its users.
package fb_pkg;

  localparam int CORDW  = 10;
  localparam int WIDTH  = 320;
  localparam int HEIGHT = 180;
  localparam int ADDRW  = $clog2(WIDTH * HEIGHT);
  localparam int COLRW  = 4;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [ADDRW-1:0] addr;
    logic [COLRW-1:0] colr;
  } px_entry_t;

endpackage

// File: rtl/fb_pixel_writer_if.sv
// Pixel stream (drawing engine -> writer) and framebuffer write port (writer -> memory).
//
// Handshakes:
//   pixel side : a pixel is taken in any cycle with drawing high; the engine may only
//                raise drawing in a cycle that follows a cycle with oe high.
//   memory side: we is the valid, mem_ready the ready; a write completes on the edge
//                where we && mem_ready, and addr/din hold until it does.
interface fb_pixel_writer_if #(
  parameter int CORDW = 10,
  parameter int ADDRW = 16,
  parameter int COLRW = 4
);

  logic [CORDW-1:0] x;
  logic [CORDW-1:0] y;
  logic             drawing;
  logic [COLRW-1:0] colr;
  logic             oe;
  logic             we;
  logic [ADDRW-1:0] addr;
  logic [COLRW-1:0] din;
  logic             mem_ready;

  modport master (
    output x, y, drawing, colr, mem_ready,
    input  oe, we, addr, din
  );

  modport slave (
    input  x, y, drawing, colr, mem_ready,
    output oe, we, addr, din
  );

endinterface

// File: rtl/fb_pixel_writer_fifo_fwft.sv
// Generic first-word-fall-through FIFO; dout shows the head whenever empty is low.
module fifo_fwft #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full queue is only accepted when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Clips incoming pixels to the framebuffer, linearises them and queues memory writes.
// Optional clip counter: define FB_PIXEL_WRITER_CLIP_CNT_EN to build it.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int CORDW  = fb_pkg::CORDW,
  parameter int WIDTH  = fb_pkg::WIDTH,
  parameter int HEIGHT = fb_pkg::HEIGHT,
  parameter int ADDRW  = fb_pkg::ADDRW,
  parameter int COLRW  = fb_pkg::COLRW,
  parameter int DEPTH  = fb_pkg::DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  fb_pixel_writer_if.slave    bus,
  output logic                flushed,
  output logic [15:0]         clip_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDRW + COLRW;

  logic             in_bounds;
  logic             s1_valid_q, s1_valid_d;
  logic [ADDRW-1:0] s1_addr_q, s1_addr_d;
  logic [COLRW-1:0] s1_colr_q, s1_colr_d;

  logic [EW-1:0]    fifo_dout;
  logic             fifo_empty, fifo_full;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      outstanding;
  logic             we;

  assign in_bounds = (int'(bus.x) < WIDTH) && (int'(bus.y) < HEIGHT);

  always_comb begin
    s1_valid_d = bus.drawing && in_bounds;
    s1_addr_d  = s1_addr_q;
    s1_colr_d  = s1_colr_q;
    if (bus.drawing) begin
      s1_addr_d = ADDRW'(bus.y) * ADDRW'(WIDTH) + ADDRW'(bus.x);
      s1_colr_d = bus.colr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_colr_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s1_colr_q  <= s1_colr_d;
    end
  end

  fifo_fwft #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (s1_valid_q),
    .din   ({s1_addr_q, s1_colr_q}),
    .pop   (we && bus.mem_ready),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Every pixel that could still land in the queue is reserved, clipped or not, so
  // the engine's one-cycle oe latency can never overrun it.
  assign outstanding = (CW+1)'(fifo_count) + (CW+1)'(s1_valid_q) + (CW+1)'(bus.drawing);

  assign we       = !fifo_empty;
  assign bus.we   = we;
  assign bus.oe   = !rst && !fifo_full && (outstanding < (CW+1)'(DEPTH));
  assign bus.addr = fifo_empty ? '0 : fifo_dout[EW-1:COLRW];
  assign bus.din  = fifo_empty ? '0 : fifo_dout[COLRW-1:0];
  assign flushed  = fifo_empty && !s1_valid_q && !bus.drawing;

`ifdef FB_PIXEL_WRITER_CLIP_CNT_EN
  logic [15:0] clip_cnt_q, clip_cnt_d;

  always_comb begin
    clip_cnt_d = clip_cnt_q;
    if (bus.drawing && !in_bounds && (clip_cnt_q != 16'hFFFF)) begin
      clip_cnt_d = clip_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clip_cnt_q <= '0;
    end else begin
      clip_cnt_q <= clip_cnt_d;
    end
  end

  assign clip_cnt = clip_cnt_q;
`else
  assign clip_cnt = '0;
`endif

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Randomised scoreboard bench for fb_pixel_writer: expected writes queued at issue, popped by a monitor.
module tb_fb_pixel_writer;
  import fb_pkg::*;

  localparam int W = ADDRW + COLRW;

  logic        clk = 1'b0;
  logic        rst;
  logic        flushed;
  logic [15:0] clip_cnt;

  fb_pixel_writer_if #(.CORDW(CORDW), .ADDRW(ADDRW), .COLRW(COLRW)) bus ();

  fb_pixel_writer dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flushed  (flushed),
    .clip_cnt (clip_cnt)
  );

  // ---------------- clock / reset-free timing ----------------
  always #5 clk = ~clk;

  int chk_cnt    = 0;
  int pass_cnt   = 0;
  int clip_exp   = 0;
  int oe_low_cnt = 0;
  int mr_mode    = 1;  // 0: mem_ready low, 1: high, 2: random
  logic [W-1:0] exp_q[$];
  logic         held_valid = 1'b0;
  logic [W-1:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [31:0] exp_clip();
`ifdef FB_PIXEL_WRITER_CLIP_CNT_EN
    return (clip_exp > 65535) ? 32'd65535 : 32'(clip_exp);
`else
    return 32'd0;
`endif
  endfunction

  // ---------------- memory ready driver ----------------
  initial begin
    bus.mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (mr_mode)
        0:       bus.mem_ready = 1'b0;
        1:       bus.mem_ready = 1'b1;
        default: bus.mem_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && !bus.oe) oe_low_cnt++;
    if (held_valid && bus.we)
      check("head_hold", 32'({bus.addr, bus.din}), 32'(held));
    if (!rst && bus.we && bus.mem_ready) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_write: got addr %0d din %0d expected no write", bus.addr, bus.din);
      end else begin
        check("wr_data", 32'({bus.addr, bus.din}), 32'(exp_q.pop_front()));
      end
    end
    held_valid = bus.we && !bus.mem_ready && !rst;
    held       = {bus.addr, bus.din};
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.drawing = 1'b0;
    end
  endtask

  // Presents one pixel, honouring oe from the previous cycle; the model is queued at issue.
  task automatic drive_pixel(input int px, input int py, input int pc);
    int        waited;
    logic      ok;
    px_entry_t e;
    waited = 0;
    forever begin
      @(negedge clk);
      ok = bus.oe;
      @(posedge clk);
      #1;
      if (ok) break;
      bus.drawing = 1'b0;
      waited++;
      if (waited > 200) begin
        chk_cnt++;
        $display("FAIL oe_wait: oe stayed low for %0d cycles expected it to rise", waited);
        return;
      end
    end
    bus.x       = px[CORDW-1:0];
    bus.y       = py[CORDW-1:0];
    bus.colr    = pc[COLRW-1:0];
    bus.drawing = 1'b1;
    if (px < WIDTH && py < HEIGHT) begin
      e.addr = ADDRW'(py * WIDTH + px);
      e.colr = pc[COLRW-1:0];
      exp_q.push_back(e);
    end else begin
      clip_exp++;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b1;
    bus.drawing = 1'b0;
    bus.x       = '0;
    bus.y       = '0;
    bus.colr    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we", 32'(bus.we), 32'd0);
    check("rst_oe", 32'(bus.oe), 32'd0);
    check("rst_flushed", 32'(flushed), 32'd1);
    check("rst_clip", 32'(clip_cnt), 32'd0);
    check("rst_addr", 32'({bus.addr, bus.din}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("oe_after_rst", 32'(bus.oe), 32'd1);

    // single pixel latency
    drive_pixel(5, 2, 3);
    idle(1);
    @(negedge clk);
    check("single_we_n1", 32'(bus.we), 32'd0);
    @(negedge clk);
    check("single_we_n2", 32'(bus.we), 32'd1);
    check("single_addr", 32'(bus.addr), 32'd645);
    check("single_din", 32'(bus.din), 32'd3);
    @(negedge clk);
    check("single_we_n3", 32'(bus.we), 32'd0);
    check("single_flushed", 32'(flushed), 32'd1);

    // clipped pixels
    drive_pixel(320, 0, 1);
    drive_pixel(0, 180, 2);
    idle(4);
    @(negedge clk);
    check("clip_cnt", 32'(clip_cnt), exp_clip());
    check("clip_flushed", 32'(flushed), 32'd1);

    // full-rate line
    oe_low_cnt = 0;
    for (int i = 10; i <= 19; i++) drive_pixel(i, 20, i % 16);
    idle(4);
    @(negedge clk);
    check("line_oe_low", 32'(oe_low_cnt), 32'd0);
    check("line_drained", 32'(exp_q.size()), 32'd0);

    // corners
    drive_pixel(319, 179, 7);
    drive_pixel(319, 180, 8);
    idle(4);
    @(negedge clk);
    check("corner_drained", 32'(exp_q.size()), 32'd0);
    check("corner_clip", 32'(clip_cnt), exp_clip());

    // back-pressure with memory stalled
    mr_mode = 0;
    for (int i = 0; i < 4; i++) drive_pixel(100 + i, 50, i + 1);
    idle(4);
    @(negedge clk);
    check("bp_oe", 32'(bus.oe), 32'd0);
    check("bp_we", 32'(bus.we), 32'd1);
    check("bp_head", 32'(bus.addr), 32'd16100);
    check("bp_flushed", 32'(flushed), 32'd0);
    fork
      drive_pixel(200, 60, 9);
      begin
        repeat (4) @(posedge clk);
        #1 mr_mode = 1;
      end
    join
    idle(6);
    @(negedge clk);
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    check("bp_flushed_end", 32'(flushed), 32'd1);

    // random traffic with random memory stalls
    mr_mode = 2;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      drive_pixel(int'($urandom_range(0, 339)), int'($urandom_range(0, 189)),
                  int'($urandom_range(0, 15)));
    end
    idle(1);
    mr_mode = 1;
    idle(10);
    @(negedge clk);
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_flushed", 32'(flushed), 32'd1);
    check("rand_clip", 32'(clip_cnt), exp_clip());

    // reset with writes pending
    mr_mode = 0;
    for (int i = 0; i < 3; i++) drive_pixel(30 + i, 40, 5);
    idle(3);
    @(negedge clk);
    check("prerst_we", 32'(bus.we), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_oe", 32'(bus.oe), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    clip_exp = 0;
    @(negedge clk);
    check("postrst_we", 32'(bus.we), 32'd0);
    check("postrst_flushed", 32'(flushed), 32'd1);
    check("postrst_clip", 32'(clip_cnt), 32'd0);
    mr_mode = 1;
    idle(6);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
